// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default CSR drain depth and the drain counter width helper.
package pipe_ctrl_pkg;

  localparam int DRAIN_CYCLES_DEF = 3;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_MEM_WAIT  = 3'd1,
    ST_CSR_DRAIN = 3'd2,
    ST_CSR_ISSUE = 3'd3,
    ST_TRAP      = 3'd4
  } ctrl_state_e;

  // A zero-depth drain still needs a one-bit counter so the flop is legal.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds a source read in ID.
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: trap, redirect, data-memory wait,
// CSR serialisation drain and load-use interlock.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [1:0] id_csr_op,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_br_taken,
  input  logic [1:0] ex_priv_ret,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       trap_req,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       ex_mem_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic [2:0] ctrl_state
);

  localparam int CNT_W = cnt_width(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_state_e      state_q, state_d;
  ctrl_state_e      resume_q, resume_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic redirect;
  logic mem_wait;
  logic csr_in_id;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign redirect   = ex_br_taken || (ex_priv_ret != 2'd0);
  assign mem_wait   = mem_req && !mem_ready;
  assign csr_in_id  = (id_csr_op != 2'd0);
  assign ctrl_state = state_q;

  always_comb begin
    state_d      = state_q;
    resume_d     = resume_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    case (state_q)
      ST_RUN, ST_CSR_DRAIN, ST_CSR_ISSUE: begin
        if (trap_req) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          cnt_d        = '0;
          state_d      = ST_TRAP;
        end else if (redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          cnt_d       = '0;
          state_d     = ST_RUN;
        end else if (mem_wait) begin
          // The drain counter stays frozen; MEM_WAIT returns to this state.
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          resume_d     = state_q;
          state_d      = ST_MEM_WAIT;
        end else if (state_q == ST_CSR_DRAIN) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_CSR_ISSUE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else if (state_q == ST_CSR_ISSUE) begin
          state_d = ST_RUN;
        end else if (csr_in_id) begin
          if (DRAIN_CYCLES > 0) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            cnt_d       = CNT_LOAD;
            state_d     = ST_CSR_DRAIN;
          end else begin
            state_d = ST_CSR_ISSUE;
          end
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
        end else begin
          state_d = resume_q;
        end
      end
      ST_TRAP: begin
        if_id_flush = 1'b1;
        state_d     = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Outputs are quiet for the whole reset window, not just after the edge.
    if (!rstn) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_RUN;
      resume_q <= ST_RUN;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
